adder_op_arbiter: RTL and testbench

Shares the operand adder between two requesters: port 0, driven by the CPU through the AXI4-lite register block, and port 1, driven by the debug VIO. It arbitrates the requests, sequences each add through a three-state FSM and returns a tagged, carry-extended sum over a valid/ready handshake. It sits between the operand sources and the result consumer, replacing the static `select` mux in front of the adder.

---
 rtl/adder_op_arbiter.sv | 92 +++++++++
 tb/tb_adder_op_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adder_op_arbiter.sv
// adder_op_arbiter: shares one adder between CPU (port 0) and VIO (port 1) with round-robin grant;
// define ADDER_ARB_VIO_PRIO_EN to give port 1 fixed priority instead.
module adder_op_arbiter #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              io_systemClk,
    input  logic              io_systemReset,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_ain,
    input  logic [DATA_W-1:0] s0_bin,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_ain,
    input  logic [DATA_W-1:0] s1_bin,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W:0]   m_sum,
    output logic              m_src,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_last, r_k, r_src;
    logic [DATA_W-1:0] r_a, r_b;
    logic [DATA_W:0]   r_sum;
    logic [CNT_W-1:0]  r_cnt0, r_cnt1;
    logic              w_g0, w_g1, w_idle, w_hs;

`ifdef ADDER_ARB_VIO_PRIO_EN
    assign w_g1 = s1_valid;
`else
    assign w_g1 = s1_valid && (!s0_valid || !r_last);
`endif
    assign w_g0   = s0_valid && !w_g1;
    assign w_idle = r_state == IDLE;
    assign w_hs   = s0_ready || s1_ready;

    assign s0_ready = w_idle && w_g0;
    assign s1_ready = w_idle && w_g1;
    assign m_valid  = r_state == RESP;
    assign busy     = !w_idle;
    assign m_sum    = r_sum;
    assign m_src    = r_src;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) r_state <= IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_hs)         w_next = EXEC;
        else if (r_state == EXEC)            w_next = RESP;
        else if (r_state == RESP && m_ready) w_next = IDLE;
    end

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            r_last <= 1'b1;
            r_k    <= 1'b0;
            r_src  <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_hs) begin
                r_a    <= s1_ready ? s1_ain : s0_ain;
                r_b    <= s1_ready ? s1_bin : s0_bin;
                r_k    <= s1_ready;
                r_last <= s1_ready;
            end
            if (r_state == EXEC) begin
                r_sum <= {1'b0, r_a} + {1'b0, r_b};
                r_src <= r_k;
            end
            // counters saturate at all-ones so long runs never wrap back to small values
            if (r_state == RESP && m_ready) begin
                if (!r_src && !(&r_cnt0)) r_cnt0 <= r_cnt0 + CNT_W'(1);
                if (r_src && !(&r_cnt1))  r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_adder_op_arbiter.sv
// tb_adder_op_arbiter: directed plus randomized checks against a transaction-level model of the arbiter.
module tb_adder_op_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b0;
    logic [W-1:0] s0_ain = '0, s0_bin = '0, s1_ain = '0, s1_bin = '0;
    logic         s0_ready, s1_ready, m_valid, m_src, busy;
    logic [W:0]   m_sum;
    logic [15:0]  cnt0, cnt1;
    logic         s0_ready_4, s1_ready_4, m_valid_4, m_src_4, busy_4;
    logic [W:0]   m_sum_4;
    logic [3:0]   cnt0_4, cnt1_4;

    always #5 clk = ~clk;

    adder_op_arbiter #(.DATA_W(W), .CNT_W(16)) dut (
        .io_systemClk(clk), .io_systemReset(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_ain(s0_ain), .s0_bin(s0_bin),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_ain(s1_ain), .s1_bin(s1_bin),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_src(m_src),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    adder_op_arbiter #(.DATA_W(W), .CNT_W(4)) dut4 (
        .io_systemClk(clk), .io_systemReset(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready_4), .s0_ain(s0_ain), .s0_bin(s0_bin),
        .s1_valid(s1_valid), .s1_ready(s1_ready_4), .s1_ain(s1_ain), .s1_bin(s1_bin),
        .m_valid(m_valid_4), .m_ready(m_ready), .m_sum(m_sum_4), .m_src(m_src_4),
        .busy(busy_4), .cnt0(cnt0_4), .cnt1(cnt1_4)
    );

    int n_chk = 0, n_pass = 0;
    int t = -1;
    bit last = 1'b1;
    int exp_sum = 0, exp_src = 0;
    int c0 = 0, c1 = 0, c40 = 0, c41 = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int pick(input bit v0, input bit v1, input bit lg);
`ifdef ADDER_ARB_VIO_PRIO_EN
        return v1 ? 1 : 0;
`else
        if (v0 && v1) return lg ? 0 : 1;
        return v1 ? 1 : 0;
`endif
    endfunction

    // t: -1 idle, 1 executing, 2 result presented
    task automatic step(input bit v0, input int a0, input int b0, input bit v1, input int a1,
                        input int b1, input bit mr, output bit h0, output bit h1);
        bit gok;
        int g;
        @(negedge clk);
        s0_valid = v0; s0_ain = W'(a0); s0_bin = W'(b0);
        s1_valid = v1; s1_ain = W'(a1); s1_bin = W'(b1);
        m_ready = mr;
        #1;
        gok = t < 0 && (v0 || v1);
        g   = pick(v0, v1, last);
        h0  = gok && g == 0;
        h1  = gok && g == 1;
        chk("s0_ready", s0_ready, int'(h0));
        chk("s1_ready", s1_ready, int'(h1));
        chk("busy", busy, int'(t >= 1));
        chk("m_valid", m_valid, int'(t == 2));
        chk("m_valid_4", m_valid_4, int'(t == 2));
        if (t == 2) begin
            chk("m_sum", m_sum, exp_sum);
            chk("m_src", m_src, exp_src);
        end
        chk("cnt0", cnt0, c0);
        chk("cnt1", cnt1, c1);
        chk("cnt0_4", cnt0_4, c40);
        chk("cnt1_4", cnt1_4, c41);
        if (gok) begin
            last    = g[0];
            exp_sum = g == 1 ? (a1 % 16) + (b1 % 16) : (a0 % 16) + (b0 % 16);
            exp_src = g;
            t = 1;
        end else if (t == 1) t = 2;
        else if (t == 2 && mr) begin
            if (exp_src == 0) begin c0 = c0 < 65535 ? c0 + 1 : c0; c40 = c40 < 15 ? c40 + 1 : c40; end
            else begin c1 = c1 < 65535 ? c1 + 1 : c1; c41 = c41 < 15 ? c41 + 1 : c41; end
            t = -1;
        end
    endtask

    task automatic run(input bit v0, input int a0, input int b0, input bit v1, input int a1,
                       input int b1, input bit mr, input int n);
        bit h0, h1;
        for (int i = 0; i < n; i++) step(v0, a0, b0, v1, a1, b1, mr, h0, h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s0_valid = 0; s1_valid = 0; m_ready = 0;
        @(negedge clk);
        #1;
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_src", m_src, 0);
        chk("rst_m_sum", m_sum, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_cnt0_4", cnt0_4, 0);
        rst = 1'b0;
        t = -1; last = 1'b1; c0 = 0; c1 = 0; c40 = 0; c41 = 0;
    endtask

    initial begin
        bit h0, h1, p0, p1;
        int a0, b0, a1, b1;
        do_reset();

        step(1, 3, 4, 0, 0, 0, 1, h0, h1);
        run(0, 0, 0, 0, 0, 0, 1, 2);
        chk("t1_sum", m_sum, 7);
        chk("t1_src", m_src, 0);
        run(0, 0, 0, 0, 0, 0, 1, 1);
        chk("t1_cnt0", cnt0, 1);

        step(0, 0, 0, 1, 15, 1, 0, h0, h1);
        run(0, 0, 0, 0, 0, 0, 0, 6);
        chk("t2_sum", m_sum, 16);
        chk("t2_cnt1_held", cnt1, 0);
        run(0, 0, 0, 0, 0, 0, 1, 2);
        chk("t2_cnt1", cnt1, 1);

        do_reset();
        run(1, 1, 2, 1, 3, 4, 1, 13);
`ifdef ADDER_ARB_VIO_PRIO_EN
        chk("t3_cnt0", cnt0, 0);
        chk("t3_cnt1", cnt1, 4);
`else
        chk("t3_cnt0", cnt0, 2);
        chk("t3_cnt1", cnt1, 2);
`endif

        do_reset();
        step(1, 4, 5, 0, 0, 0, 0, h0, h1);
        run(0, 0, 0, 0, 0, 0, 0, 2);
        chk("t4_sum9", m_sum, 9);
        do_reset();

        run(1, 1, 1, 0, 0, 0, 1, 52);
        chk("sat_cnt4", cnt0_4, 15);
        chk("sat_cnt16", cnt0, 17);

        do_reset();
        step(1, 2, 1, 0, 0, 0, 1, h0, h1);
        run(0, 5, 1, 0, 0, 0, 1, 2);
        chk("t6_sum", m_sum, 3);
        run(0, 0, 0, 0, 0, 0, 1, 1);

        do_reset();
        p0 = 0; p1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!p0) begin a0 = $urandom_range(15); b0 = $urandom_range(15); p0 = ($urandom % 3) == 0; end
            if (!p1) begin a1 = $urandom_range(15); b1 = $urandom_range(15); p1 = ($urandom % 3) == 0; end
            step(p0, a0, b0, p1, a1, b1, 1'($urandom % 2), h0, h1);
            if (h0) p0 = 0;
            if (h1) p1 = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
